i2s_rx_master: RTL and testbench

- Parametrised I2S/left-justified master receiver for the audio ADC front end (PCM1808-class).
- Generates scki/bck/lrck from clk, deserialises din into left/right samples of configurable width, and presents each stereo frame on a valid/ready output port.
- Adds sign extension, a sticky overrun flag, a run enable, and a standard-I2S/left-justified mode select.
- Sits between the ADC pins and the downstream equaliser/SPI path.

---
 rtl/i2s_pkg.sv | 37 +++
 rtl/i2s_clkgen.sv | 61 ++++++
 rtl/i2s_rx_master.sv | 140 ++++++++++++++
 tb/tb_i2s_rx_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S master receiver.
package i2s_pkg;

  // Serial format select values for the mode input.
  localparam logic I2S_MODE_STD = 1'b0;  // data MSB one bck after the lrck edge
  localparam logic I2S_MODE_LJ  = 1'b1;  // data MSB aligned with the lrck edge

  // Default geometry matching a PCM1808-class ADC at 256 fs.
  localparam int DEF_DATA_W       = 24;
  localparam int DEF_SLOT_W       = 32;
  localparam int DEF_BCK_DIV_LOG2 = 2;
  localparam int DEF_OUT_W        = 24;

  // Widest sample the extension helper can produce.
  localparam int EXT_MAX_W = 64;

  // Extends the low data_w bits of v to EXT_MAX_W bits. When sign_ext is set,
  // bit data_w-1 is replicated upward; otherwise the upper bits are zero.
  function automatic logic [EXT_MAX_W-1:0] extend_sample(
    input logic [EXT_MAX_W-1:0] v,
    input int                   data_w,
    input logic                 sign_ext
  );
    logic                 fill;
    logic [EXT_MAX_W-1:0] r;
    r    = v;
    fill = 1'b0;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i == data_w - 1) fill = sign_ext & v[i];
    end
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i >= data_w) r[i] = fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Timing generator: one free-running counter yields the registered bit and
// frame clocks plus the single-cycle strobes the capture logic needs.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SLOT_W       = DEF_SLOT_W,
  parameter int BCK_DIV_LOG2 = DEF_BCK_DIV_LOG2,
  localparam int IDX_W       = $clog2(SLOT_W),
  localparam int CNT_W       = BCK_DIV_LOG2 + IDX_W + 1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             bck,
  output logic             lrck,
  output logic             tick,
  output logic [IDX_W-1:0] bit_idx,
  output logic             slot,
  output logic             frame_start
);

  // Low counter value of the clk cycle just before bck rises.
  localparam logic [BCK_DIV_LOG2-1:0] TICK_LOW =
    BCK_DIV_LOG2'((1 << (BCK_DIV_LOG2 - 1)) - 1);

  if (BCK_DIV_LOG2 < 1) begin : g_bad_div
    $error("i2s_clkgen: BCK_DIV_LOG2 must be at least 1");
  end
  if ((SLOT_W & (SLOT_W - 1)) != 0) begin : g_bad_slot
    $error("i2s_clkgen: SLOT_W must be a power of two");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Count while enabled; a disabled generator parks at the start of a frame.
  always_comb begin
    cnt_next = '0;
    if (en) cnt_next = cnt + 1'b1;
  end

  // bck/lrck come straight from flops fed by the next count, so they track
  // the counter bits exactly and never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      bck  <= 1'b0;
      lrck <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      bck  <= cnt_next[BCK_DIV_LOG2-1];
      lrck <= cnt_next[CNT_W-1];
    end
  end

  assign tick        = en && (cnt[BCK_DIV_LOG2-1:0] == TICK_LOW);
  assign bit_idx     = cnt[CNT_W-2:BCK_DIV_LOG2];
  assign slot        = cnt[CNT_W-1];
  assign frame_start = en && (cnt == '0);

endmodule

// File: rtl/i2s_rx_master.sv
// I2S / left-justified master receiver: deserialises din into stereo frames
// and offers each frame on a valid/ready port with a sticky overrun flag.
module i2s_rx_master
  import i2s_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int SLOT_W       = DEF_SLOT_W,
  parameter int BCK_DIV_LOG2 = DEF_BCK_DIV_LOG2,
  parameter int OUT_W        = DEF_OUT_W,
  parameter int SIGN_EXT     = 1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             din,
  output logic             scki,
  output logic             bck,
  output logic             lrck,
  output logic [OUT_W-1:0] out_left,
  output logic [OUT_W-1:0] out_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int IDX_W = $clog2(SLOT_W);
  localparam logic [IDX_W-1:0] LAST_STD = IDX_W'(DATA_W);
  localparam logic [IDX_W-1:0] LAST_LJ  = IDX_W'(DATA_W - 1);

  if (DATA_W + 1 > SLOT_W) begin : g_bad_data_w
    $error("i2s_rx_master: DATA_W+1 must not exceed SLOT_W");
  end
  if (OUT_W < DATA_W) begin : g_bad_out_w
    $error("i2s_rx_master: OUT_W must be at least DATA_W");
  end
  if (OUT_W > EXT_MAX_W) begin : g_wide_out_w
    $error("i2s_rx_master: OUT_W exceeds the extension helper width");
  end
  if (BCK_DIV_LOG2 < 1) begin : g_bad_div
    $error("i2s_rx_master: BCK_DIV_LOG2 must be at least 1");
  end

  logic             tick;
  logic             slot;
  logic             frame_start;
  logic [IDX_W-1:0] bit_idx;

  i2s_clkgen #(
    .SLOT_W       (SLOT_W),
    .BCK_DIV_LOG2 (BCK_DIV_LOG2)
  ) u_clkgen (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .bck         (bck),
    .lrck        (lrck),
    .tick        (tick),
    .bit_idx     (bit_idx),
    .slot        (slot),
    .frame_start (frame_start)
  );

  // The ADC runs from the system clock directly.
  assign scki = clk;

  logic              mode_q;
  logic              mode_eff;
  logic              in_window;
  logic              is_last;
  logic [DATA_W-1:0] sh_l;
  logic [DATA_W-1:0] sh_r;
  logic              frame_done_q;

  // Mode only changes at cnt==0, so the first cycle of a frame already uses
  // the incoming value while the rest of the frame uses the latched copy.
  always_comb begin
    in_window = 1'b0;
    is_last   = 1'b0;
    mode_eff  = frame_start ? mode : mode_q;
    if (mode_eff == I2S_MODE_LJ) begin
      in_window = (bit_idx <= LAST_LJ);
      is_last   = (bit_idx == LAST_LJ);
    end else begin
      in_window = (bit_idx != '0) && (bit_idx <= LAST_STD);
      is_last   = (bit_idx == LAST_STD);
    end
  end

  // Shift din into the active slot's register on each in-window sample tick;
  // flag the frame as done when the right slot's last bit is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= I2S_MODE_STD;
      sh_l         <= '0;
      sh_r         <= '0;
      frame_done_q <= 1'b0;
    end else if (!en) begin
      sh_l         <= '0;
      sh_r         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (frame_start) mode_q <= mode;
      frame_done_q <= tick && slot && is_last;
      if (tick && in_window) begin
        if (slot) sh_r <= (sh_r << 1) | DATA_W'(din);
        else      sh_l <= (sh_l << 1) | DATA_W'(din);
      end
    end
  end

  // Output handshake: a frame moves on a clk edge where out_valid && out_ready.
  // out_valid never drops without a transfer and out_left/out_right are stable
  // while it waits; a completed frame that finds the port still occupied is
  // dropped and recorded in overrun.
  logic drop;
  assign drop = frame_done_q && out_valid && !out_ready;

  // Output register, valid flag and sticky overrun (set beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_done_q && !drop) begin
        out_left  <= OUT_W'(extend_sample(EXT_MAX_W'(sh_l), DATA_W, SIGN_EXT != 0));
        out_right <= OUT_W'(extend_sample(EXT_MAX_W'(sh_r), DATA_W, SIGN_EXT != 0));
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_master.sv
// Directed bench for i2s_rx_master with a simple ADC serialiser model.
module tb_i2s_rx_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic en, mode, din, out_ready, overrun_clr;

  // default instance
  logic        scki, bck, lrck, out_valid, overrun;
  logic [23:0] out_left, out_right;
  // OUT_W=32 sign-extending instance
  logic        s_scki, s_bck, s_lrck, s_valid, s_overrun;
  logic [31:0] s_left, s_right;
  // OUT_W=32 zero-extending instance
  logic        z_scki, z_bck, z_lrck, z_valid, z_overrun;
  logic [31:0] z_left, z_right;

  i2s_rx_master u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din),
    .scki(scki), .bck(bck), .lrck(lrck),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  i2s_rx_master #(.OUT_W(32), .SIGN_EXT(1)) u_dut_s (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din),
    .scki(s_scki), .bck(s_bck), .lrck(s_lrck),
    .out_left(s_left), .out_right(s_right), .out_valid(s_valid),
    .out_ready(out_ready), .overrun(s_overrun), .overrun_clr(overrun_clr)
  );

  i2s_rx_master #(.OUT_W(32), .SIGN_EXT(0)) u_dut_z (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din),
    .scki(z_scki), .bck(z_bck), .lrck(z_lrck),
    .out_left(z_left), .out_right(z_right), .out_valid(z_valid),
    .out_ready(out_ready), .overrun(z_overrun), .overrun_clr(overrun_clr)
  );

  // ---------------- ADC model ----------------
  // Frame position counter of the ADC: 4 clk per bit, 32 bits per slot.
  logic [7:0]  tb_cnt;
  logic [23:0] adc_l, adc_r;
  logic        adc_mode;
  logic [23:0] adc_word;
  int          adc_pos;

  always @(posedge clk or posedge reset) begin
    if (reset)    tb_cnt <= 8'd0;
    else if (!en) tb_cnt <= 8'd0;
    else          tb_cnt <= tb_cnt + 8'd1;
  end

  // MSB at bit 1 of the slot (I2S) or bit 0 (left-justified); junk elsewhere.
  always @(negedge clk) begin
    adc_word = tb_cnt[7] ? adc_r : adc_l;
    adc_pos  = int'(tb_cnt[6:2]) - (adc_mode ? 0 : 1);
    if (adc_pos >= 0 && adc_pos < 24) din = adc_word[23 - adc_pos];
    else                              din = 1'($urandom_range(0, 1));
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b0; mode = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    adc_mode = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < limit);
  endtask

  task automatic wait_cnt(input logic [7:0] v, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt != v && n < 600);
    ok = (tb_cnt == v);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    #1;
    n_checks++; if (out_valid !== 1'b0 || overrun !== 1'b0) $display("FAIL reset_flags: got valid=%b overrun=%b expected 0 0", out_valid, overrun); else n_pass++;
    n_checks++; if (out_left !== 24'h0 || out_right !== 24'h0) $display("FAIL reset_data: got %h %h expected 0 0", out_left, out_right); else n_pass++;
    n_checks++; if (bck !== 1'b0 || lrck !== 1'b0) $display("FAIL reset_clocks: got bck=%b lrck=%b expected 0 0", bck, lrck); else n_pass++;
    n_checks++; if (s_left !== 32'h0 || z_right !== 32'h0 || s_valid !== 1'b0) $display("FAIL reset_wide: got %h %h %b expected 0 0 0", s_left, z_right, s_valid); else n_pass++;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bck !== 1'b0 || lrck !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL idle_disabled: got %0d active cycles expected 0", bad); else n_pass++;
  endtask

  task automatic test_clocks();
    int bck_r[2], lr_r[2], nb, nl, bad_scki;
    logic pb, pl;
    apply_reset();
    en = 1'b1;
    nb = 0; nl = 0; pb = 1'b0; pl = 1'b0; bad_scki = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (scki !== 1'b0) bad_scki++;
      if (bck === 1'b1 && pb === 1'b0 && nb < 2) begin bck_r[nb] = k; nb++; end
      if (lrck === 1'b1 && pl === 1'b0 && nl < 2) begin lr_r[nl] = k; nl++; end
      pb = bck; pl = lrck;
      #6;
      if (scki !== 1'b1) bad_scki++;
    end
    n_checks++; if (nb != 2 || bck_r[0] != 2 || bck_r[1] - bck_r[0] != 4) $display("FAIL bck_period: got first=%0d period=%0d expected 2 4", bck_r[0], bck_r[1] - bck_r[0]); else n_pass++;
    n_checks++; if (nl != 2 || lr_r[0] != 128 || lr_r[1] - lr_r[0] != 256) $display("FAIL lrck_period: got first=%0d period=%0d expected 128 256", lr_r[0], lr_r[1] - lr_r[0]); else n_pass++;
    n_checks++; if (bad_scki != 0) $display("FAIL scki_follow: got %0d bad samples expected 0", bad_scki); else n_pass++;
  endtask

  task automatic test_basic();
    int n;
    apply_reset();
    out_ready = 1'b1; adc_l = 24'hA5A5A5; adc_r = 24'h800001;
    en = 1'b1;
    wait_valid(400, n);
    n_checks++; if (n != 227) $display("FAIL basic_latency: got %0d cycles expected 227", n); else n_pass++;
    n_checks++; if (out_left !== 24'hA5A5A5) $display("FAIL basic_left: got %h expected a5a5a5", out_left); else n_pass++;
    n_checks++; if (out_right !== 24'h800001) $display("FAIL basic_right: got %h expected 800001", out_right); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_pulse: got valid=%b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_sign_ext();
    int n;
    apply_reset();
    out_ready = 1'b1; adc_l = 24'h7FFFFF; adc_r = 24'h800001;
    en = 1'b1;
    wait_valid(400, n);
    n_checks++; if (out_left !== 24'h7FFFFF || out_right !== 24'h800001) $display("FAIL ext_narrow: got %h %h expected 7fffff 800001", out_left, out_right); else n_pass++;
    n_checks++; if (s_valid !== 1'b1 || s_right !== 32'hFF800001) $display("FAIL ext_sign_right: got v=%b %h expected 1 ff800001", s_valid, s_right); else n_pass++;
    n_checks++; if (s_left !== 32'h007FFFFF) $display("FAIL ext_sign_left: got %h expected 007fffff", s_left); else n_pass++;
    n_checks++; if (z_valid !== 1'b1 || z_right !== 32'h00800001) $display("FAIL ext_zero_right: got v=%b %h expected 1 00800001", z_valid, z_right); else n_pass++;
    n_checks++; if (z_left !== 32'h007FFFFF) $display("FAIL ext_zero_left: got %h expected 007fffff", z_left); else n_pass++;
  endtask

  task automatic test_lj_mode();
    int n;
    bit ok;
    apply_reset();
    mode = 1'b1; adc_mode = 1'b1; out_ready = 1'b1;
    adc_l = 24'h123456; adc_r = 24'hFEDCBA;
    en = 1'b1;
    wait_valid(400, n);
    n_checks++; if (n != 223) $display("FAIL lj_latency: got %0d cycles expected 223", n); else n_pass++;
    n_checks++; if (out_left !== 24'h123456 || out_right !== 24'hFEDCBA) $display("FAIL lj_frame1: got %h %h expected 123456 fedcba", out_left, out_right); else n_pass++;
    adc_l = 24'h13579B; adc_r = 24'hECA864;
    wait_cnt(8'd64, ok);
    n_checks++; if (!ok) $display("FAIL lj_wait_cnt: got timeout expected cnt 64"); else n_pass++;
    mode = 1'b0;
    wait_valid(400, n);
    n_checks++; if (out_valid !== 1'b1 || out_left !== 24'h13579B || out_right !== 24'hECA864) $display("FAIL lj_midframe_switch: got v=%b %h %h expected 1 13579b eca864", out_valid, out_left, out_right); else n_pass++;
    adc_mode = 1'b0; adc_l = 24'h2468AC; adc_r = 24'hFDB975;
    wait_valid(400, n);
    n_checks++; if (out_valid !== 1'b1 || out_left !== 24'h2468AC || out_right !== 24'hFDB975) $display("FAIL lj_next_frame_std: got v=%b %h %h expected 1 2468ac fdb975", out_valid, out_left, out_right); else n_pass++;
  endtask

  task automatic test_overrun();
    int n, m;
    bit ok;
    apply_reset();
    out_ready = 1'b0; adc_l = 24'h111111; adc_r = 24'h222222;
    en = 1'b1;
    wait_valid(400, n);
    n_checks++; if (out_valid !== 1'b1 || out_left !== 24'h111111) $display("FAIL ovr_f1: got v=%b %h expected 1 111111", out_valid, out_left); else n_pass++;
    adc_l = 24'h333333; adc_r = 24'h444444;
    m = 0;
    do begin @(negedge clk); m++; end while (overrun !== 1'b1 && m < 400);
    n_checks++; if (m != 256) $display("FAIL ovr_set_time: got %0d cycles expected 256", m); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || out_left !== 24'h111111 || out_right !== 24'h222222) $display("FAIL ovr_hold: got v=%b %h %h expected 1 111111 222222", out_valid, out_left, out_right); else n_pass++;
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun); else n_pass++;
    adc_l = 24'h555555; adc_r = 24'h666666;
    wait_cnt(8'd226, ok);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (!ok || out_valid !== 1'b1 || out_left !== 24'h555555 || out_right !== 24'h666666) $display("FAIL ovr_ready_same_cycle: got v=%b %h %h expected 1 555555 666666", out_valid, out_left, out_right); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_not_set: got %b expected 0", overrun); else n_pass++;
    adc_l = 24'h777777; adc_r = 24'h888888;
    wait_cnt(8'd226, ok);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++; if (!ok || overrun !== 1'b1) $display("FAIL ovr_set_wins: got %b expected 1", overrun); else n_pass++;
    n_checks++; if (out_left !== 24'h555555 || out_right !== 24'h666666) $display("FAIL ovr_keep_old: got %h %h expected 555555 666666", out_left, out_right); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit ok;
    apply_reset();
    out_ready = 1'b0; adc_l = 24'hABCDEF; adc_r = 24'hFEDCBA;
    en = 1'b1;
    wait_valid(400, n);
    adc_l = 24'h0F0F0F; adc_r = 24'hF0F0F0;
    wait_cnt(8'd42, ok);
    reset = 1'b1;
    #1;
    n_checks++; if (!ok || out_valid !== 1'b0 || out_left !== 24'h0 || out_right !== 24'h0) $display("FAIL rst_mid_outputs: got v=%b %h %h expected 0 0 0", out_valid, out_left, out_right); else n_pass++;
    n_checks++; if (bck !== 1'b0 || lrck !== 1'b0 || overrun !== 1'b0) $display("FAIL rst_mid_clocks: got bck=%b lrck=%b ovr=%b expected 0 0 0", bck, lrck, overrun); else n_pass++;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    wait_valid(400, n);
    n_checks++; if (n != 227 || out_left !== 24'h0F0F0F || out_right !== 24'hF0F0F0) $display("FAIL rst_mid_next_frame: got n=%0d %h %h expected 227 0f0f0f f0f0f0", n, out_left, out_right); else n_pass++;
  endtask

  task automatic test_enable();
    int n, bad;
    bit ok;
    apply_reset();
    out_ready = 1'b1; adc_l = 24'h5A5A5A; adc_r = 24'hC3C3C3;
    en = 1'b1;
    wait_cnt(8'd60, ok);
    en = 1'b0;
    adc_l = 24'h0F1E2D; adc_r = 24'h3C4B5A;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bck !== 1'b0 || lrck !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    n_checks++; if (!ok || bad != 0) $display("FAIL en_low_idle: got %0d active cycles expected 0", bad); else n_pass++;
    en = 1'b1;
    wait_valid(400, n);
    n_checks++; if (n != 227) $display("FAIL en_restart_latency: got %0d expected 227", n); else n_pass++;
    n_checks++; if (out_left !== 24'h0F1E2D || out_right !== 24'h3C4B5A) $display("FAIL en_restart_frame: got %h %h expected 0f1e2d 3c4b5a", out_left, out_right); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; en = 1'b0; mode = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    adc_l = 24'h0; adc_r = 24'h0; adc_mode = 1'b0;
    test_reset();
    test_clocks();
    test_basic();
    test_sign_ext();
    test_lj_mode();
    test_overrun();
    test_reset_mid_frame();
    test_enable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
